btn_enable_ctrl: RTL and testbench

BTN_ENABLE_CTRL -- requirements
Module: btn_enable_ctrl

---
 rtl/btn_enable_ctrl.sv | 120 ++++++++++++
 tb/tb_btn_enable_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_enable_ctrl.sv
// Debounced pushbutton that toggles an enable level once per qualified press.
// Synchronizer -> 4-state debounce FSM -> registered en / press_pulse / btn_state.
module btn_enable_ctrl #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter bit          EN_INIT   = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_in,
    output logic en,
    output logic press_pulse,
    output logic btn_state
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("btn_enable_ctrl: DB_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q;
    logic          en_q, en_d;
    logic          pulse_q, pulse_d;
    logic          lvl_q, lvl_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            en_q    <= EN_INIT;
            pulse_q <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            en_q    <= en_d;
            pulse_q <= pulse_d;
            lvl_q   <= lvl_d;
        end
    end

    // cnt saturates at CNT_MAX by construction: reaching it always leaves the state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d    = en_q;
        pulse_d = 1'b0;
        lvl_d   = lvl_q;
        if (state_q == PRESS_CHK && state_d == HELD) begin
            en_d    = ~en_q;
            pulse_d = 1'b1;
            lvl_d   = 1'b1;
        end
        if (state_q == RELEASE_CHK && state_d == IDLE) begin
            lvl_d = 1'b0;
        end
    end

    assign en          = en_q;
    assign press_pulse = pulse_q;
    assign btn_state   = lvl_q;

endmodule

// File: tb/tb_btn_enable_ctrl.sv
// Bench for btn_enable_ctrl: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_btn_enable_ctrl;

    localparam int DB = 4;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_in = 1'b0;
    logic en, press_pulse, btn_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    btn_enable_ctrl #(
        .DB_CYCLES(DB),
        .EN_INIT  (1'b0)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .en         (en),
        .press_pulse(press_pulse),
        .btn_state  (btn_state)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Model: the input reaches the decision point two edges late; the
    // debounced level flips once the delayed input has disagreed with it
    // on DB+1 consecutive edges. Rising flips toggle en and strobe.
    logic m_s1 = 0, m_s2 = 0, m_lvl = 0, m_en = 0, m_pulse = 0;
    int   m_run = 0;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0;
            m_en = 0; m_pulse = 0; m_run = 0;
        end else begin
            m_pulse = 0;
            if (m_s2 != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == DB + 1) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    if (m_lvl) begin
                        m_en    = ~m_en;
                        m_pulse = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    end

    task automatic chk(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", nm, $time, got, want);
        end
    endtask

    task automatic lit(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    int   pulses = 0, pulse_edge = -1;
    int   rises = 0, rise_edge = -1, fall_edge = -1;
    logic prev_bs = 0;

    always @(negedge clk_in) begin
        chk("en", en, m_en);
        chk("press_pulse", press_pulse, m_pulse);
        chk("btn_state", btn_state, m_lvl);
        if (press_pulse) begin
            pulses++;
            pulse_edge = cyc;
        end
        if (btn_state && !prev_bs) begin
            rises++;
            rise_edge = cyc;
        end
        if (!btn_state && prev_bs) fall_edge = cyc;
        prev_bs = btn_state;
    end

    task automatic drive(input logic b, input int n);
        btn_in = b;
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk_in);
        #2;
        rst_n = 1'b1;
    endtask

    int p0, r0, k, r, e;

    initial begin
        // reset held 3 edges with button idle
        repeat (3) @(posedge clk_in);
        #2;
        lit("rst_en", int'(en), 0);
        lit("rst_pulse", int'(press_pulse), 0);
        lit("rst_state", int'(btn_state), 0);
        rst_n = 1'b1;
        drive(0, 6);
        lit("post_rst_en", int'(en), 0);

        // clean press sampled first at edge 10
        p0 = pulses;
        k  = cyc + 1;
        lit("press_start_edge", k, 10);
        drive(1, 20);
        r = cyc + 1;
        drive(0, 12);
        lit("press_pulses", pulses - p0, 1);
        lit("press_pulse_edge", pulse_edge, 16);
        lit("press_rise_edge", rise_edge, 16);
        lit("release_fall_edge", fall_edge, r + 6);
        lit("press_en", int'(en), 1);

        // short glitches: no qualification
        p0 = pulses;
        r0 = rises;
        drive(1, 3); drive(0, 2); drive(1, 3); drive(0, 12);
        lit("glitch_pulses", pulses - p0, 0);
        lit("glitch_rises", rises - r0, 0);
        lit("glitch_en", int'(en), 1);

        // DB high cycles is one short; DB+1 qualifies
        p0 = pulses;
        drive(1, DB); drive(0, 12);
        lit("short_pulses", pulses - p0, 0);
        k = cyc + 1;
        drive(1, DB + 1); drive(0, 12);
        lit("min_pulses", pulses - p0, 1);
        lit("min_pulse_edge", pulse_edge, k + 6);
        lit("min_en", int'(en), 0);

        // release bounces stay in HELD, second press toggles back
        do_reset(2);
        drive(0, 3);
        p0 = pulses;
        r0 = rises;
        drive(1, 10);
        drive(0, 3); drive(1, 2); drive(0, 3); drive(1, 2); drive(0, 12);
        lit("bounce_rises", rises - r0, 1);
        lit("bounce_en_mid", int'(en), 1);
        drive(1, 10); drive(0, 12);
        lit("bounce_pulses", pulses - p0, 2);
        lit("bounce_en_end", int'(en), 0);

        // reset during PRESS_CHK aborts; held button re-qualifies
        do_reset(2);
        drive(0, 3);
        drive(1, 3);
        p0 = pulses;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        lit("abort_pulses", pulses - p0, 0);
        lit("abort_en", int'(en), 0);
        rst_n = 1'b1;
        e = cyc;
        drive(1, 15);
        lit("requal_pulses", pulses - p0, 1);
        lit("requal_pulse_edge", pulse_edge, e + 7);
        lit("requal_en", int'(en), 1);
        drive(0, 12);

        // long hold: no auto-repeat
        do_reset(2);
        drive(0, 3);
        p0 = pulses;
        drive(1, 1000);
        lit("hold_pulses", pulses - p0, 1);
        lit("hold_en", int'(en), 1);
        drive(0, 12);
        lit("hold_rel_pulses", pulses - p0, 1);
        lit("hold_rel_en", int'(en), 1);
        lit("hold_rel_state", int'(btn_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
